// File: rtl/seg_scan_display.sv
// Multi-channel 7-segment scan driver: snapshots one debug word per frame and scans it onto common-anode digits.
// Latency: seg/select update one clk after the digit index advances; channel/snapshot change only at frame end.
// Backpressure: none; hold freezes the snapshot, and async ch_data changes never affect a frame in progress.
module seg_scan_display #(
    parameter int NUM_CH     = 4,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ROT_FRAMES = 256,
    parameter int LZ_BLANK   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH*4*NUM_DIGITS-1:0]   ch_data,
    input  logic [$clog2(NUM_CH)-1:0]        ch_sel,
    input  logic                             auto_rot,
    input  logic                             hold,
    output logic [6:0]                       seg,
    output logic [NUM_DIGITS-1:0]            select,
    output logic [$clog2(NUM_CH)-1:0]        cur_ch
);

    localparam int CW  = 4 * NUM_DIGITS;
    localparam int CHW = $clog2(NUM_CH);
    localparam int DVW = $clog2(SCAN_DIV);
    localparam int DGW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW  = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;

    logic [DVW-1:0]        div;
    logic [DGW-1:0]        dig;
    logic [FW-1:0]         fcnt;
    logic [FW-1:0]         fcnt_nxt;
    logic [CW-1:0]         snap;
    logic                  upd;
    logic                  tick;
    logic                  frame_end;
    logic [CHW-1:0]        next_ch;
    logic [CW-1:0]         sel_data;
    logic [3:0]            nib;
    logic                  lz;
    logic [NUM_DIGITS-1:0] sel_n;

    // Active-low hex decode, segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick      = (div == DVW'(SCAN_DIV - 1));
    assign frame_end = tick && (dig == DGW'(NUM_DIGITS - 1));

    // Channel chosen for the next frame and the rotate frame counter's next value
    always_comb begin
        next_ch  = cur_ch;
        fcnt_nxt = fcnt;
        if (!auto_rot) begin
            fcnt_nxt = '0;
            if (32'(ch_sel) < NUM_CH) begin
                next_ch = ch_sel;
            end else begin
                next_ch = '0;
            end
        end else if (fcnt == FW'(ROT_FRAMES - 1)) begin
            fcnt_nxt = '0;
            next_ch  = (cur_ch == CHW'(NUM_CH - 1)) ? '0 : cur_ch + CHW'(1);
        end else begin
            fcnt_nxt = fcnt + FW'(1);
        end
    end

    // Select the word of the channel that becomes current at frame end
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (next_ch == CHW'(k)) begin
                sel_data = ch_data[k*CW +: CW];
            end
        end
    end

    // Nibble, digit enable and leading-zero status for the digit now being scanned
    always_comb begin
        nib   = '0;
        lz    = 1'b0;
        sel_n = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (dig == DGW'(d)) begin
                nib      = snap[d*4 +: 4];
                sel_n[d] = 1'b0;
                if (d > 0 && (snap >> (4 * d)) == '0) begin
                    lz = 1'b1;
                end
            end
        end
    end

    // Scan timing: divider, digit index, and a one-cycle-delayed tick for output refresh
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            dig <= '0;
            upd <= 1'b0;
        end else begin
            upd <= tick;
            if (tick) begin
                div <= '0;
                dig <= (dig == DGW'(NUM_DIGITS - 1)) ? '0 : dig + DGW'(1);
            end else begin
                div <= div + DVW'(1);
            end
        end
    end

    // Frame-synchronous channel switch and snapshot load; frame counter idles while manual
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt   <= '0;
            cur_ch <= '0;
            snap   <= '0;
        end else begin
            if (!auto_rot) begin
                fcnt <= '0;
            end else if (frame_end) begin
                fcnt <= fcnt_nxt;
            end
            if (frame_end) begin
                cur_ch <= next_ch;
                if (!hold) begin
                    snap <= sel_data;
                end
            end
        end
    end

    // Registered segment and digit drive, refreshed once per digit slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg    <= 7'h7F;
            select <= '1;
        end else if (upd) begin
            select <= sel_n;
            seg    <= (LZ_BLANK != 0 && lz) ? 7'h7F : hex7(nib);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: three instances (base, leading-zero blanking, 3 channels).
// Timing is tracked as posedge count since reset release; outputs are sampled on the falling edge.
// Expected segment codes are hand-derived from the hex table.
module tb_seg_scan_display;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S6  = 7'b0000010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] SB  = 7'b0000011;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SD  = 7'b0100001;
    localparam logic [6:0] SE  = 7'b0000110;
    localparam logic [6:0] SF  = 7'b0001110;
    localparam logic [6:0] BLK = 7'h7F;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc;
    int   n_tests = 0;
    int   n_fail = 0;

    // base instance
    logic [15:0] d_ch0, d_ch1, d_ch2, d_ch3;
    logic [63:0] d_data;
    logic [1:0]  d_sel;
    logic        d_rot, d_hold;
    logic [6:0]  d_seg;
    logic [3:0]  d_select;
    logic [1:0]  d_cur;

    // leading-zero instance
    logic [15:0] l_ch0;
    logic [63:0] l_data;
    logic [6:0]  l_seg;
    logic [3:0]  l_select;
    logic [1:0]  l_cur;

    // three-channel instance
    logic [47:0] c_data;
    logic [1:0]  c_sel;
    logic [6:0]  c_seg;
    logic [3:0]  c_select;
    logic [1:0]  c_cur;

    assign d_data = {d_ch3, d_ch2, d_ch1, d_ch0};
    assign l_data = {48'h0, l_ch0};
    assign c_data = {16'h0000, 16'h1111, 16'hABCD};

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    seg_scan_display #(.NUM_CH(4), .NUM_DIGITS(4), .SCAN_DIV(4), .ROT_FRAMES(2), .LZ_BLANK(0)) u_dut (
        .clk(clk), .reset(reset), .ch_data(d_data), .ch_sel(d_sel), .auto_rot(d_rot),
        .hold(d_hold), .seg(d_seg), .select(d_select), .cur_ch(d_cur));

    seg_scan_display #(.NUM_CH(4), .NUM_DIGITS(4), .SCAN_DIV(4), .ROT_FRAMES(2), .LZ_BLANK(1)) u_lz (
        .clk(clk), .reset(reset), .ch_data(l_data), .ch_sel(2'd0), .auto_rot(1'b0),
        .hold(1'b0), .seg(l_seg), .select(l_select), .cur_ch(l_cur));

    seg_scan_display #(.NUM_CH(3), .NUM_DIGITS(4), .SCAN_DIV(4), .ROT_FRAMES(2), .LZ_BLANK(0)) u_c3 (
        .clk(clk), .reset(reset), .ch_data(c_data), .ch_sel(c_sel), .auto_rot(1'b0),
        .hold(1'b0), .seg(c_seg), .select(c_select), .cur_ch(c_cur));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // advance to the falling edge after posedge n (counted from reset release)
    task automatic at(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reach_cycle", cyc, n);
    endtask

    task automatic disp(input string tag, input int n, input logic [6:0] es, input logic [3:0] esel);
        at(n);
        check_eq({tag, "_seg"}, d_seg, es);
        check_eq({tag, "_sel"}, d_select, esel);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        d_ch0 = 16'hC0DE; d_ch1 = 16'h12AF; d_ch2 = 16'h3456; d_ch3 = 16'h789B;
        d_sel = 2'd1; d_rot = 1'b0; d_hold = 1'b0;
        l_ch0 = 16'h0005;
        c_sel = 2'd2;

        // ---- phase A: base instance ----
        repeat (3) @(negedge clk);
        check_eq("rst_sel", d_select, 4'hF);
        check_eq("rst_seg", d_seg, BLK);
        check_eq("rst_cur", d_cur, 0);
        release_reset();

        disp("pre_tick", 4, BLK, 4'b1111);
        check_eq("pre_tick_cur", d_cur, 0);
        disp("first_digit1_zero", 5, S0, 4'b1101);
        at(16);
        check_eq("manual_cur1", d_cur, 1);
        check_eq("c3_cur2", c_cur, 2);
        disp("f1_d0", 17, SF, 4'b1110);
        disp("f1_d1", 21, SA, 4'b1101);
        disp("f1_d2", 25, S2, 4'b1011);
        disp("f1_d3", 29, S1, 4'b0111);

        d_hold = 1'b1; d_ch1 = 16'h3333;
        disp("hold_f2_d0", 33, SF, 4'b1110);
        disp("hold_f3_d3", 61, S1, 4'b0111);
        disp("hold_f4_d1", 69, SA, 4'b1101);
        d_hold = 1'b0;
        disp("unhold_d0", 81, S3, 4'b1110);
        at(85);
        d_ch1 = 16'h4444;
        disp("midframe_change_d2", 89, S3, 4'b1011);
        disp("unhold_d3", 93, S3, 4'b0111);

        d_sel = 2'd0;
        at(96);
        check_eq("manual_cur0", d_cur, 0);
        disp("ch0_d1", 101, SD, 4'b1101);
        d_rot = 1'b1;
        at(127);
        check_eq("rot_hold0", d_cur, 0);
        at(128);
        check_eq("rot_to1", d_cur, 1);
        disp("rot1_d0", 129, S4, 4'b1110);
        at(159);
        check_eq("rot_hold1", d_cur, 1);
        at(160);
        check_eq("rot_to2", d_cur, 2);
        disp("rot2_d0", 161, S6, 4'b1110);
        at(192);
        check_eq("rot_to3", d_cur, 3);
        disp("rot3_d0", 193, SB, 4'b1110);
        disp("rot3_d3", 205, S7, 4'b0111);
        at(224);
        check_eq("rot_wrap0", d_cur, 0);
        disp("rot0_d0", 225, SE, 4'b1110);
        disp("rot0_d1", 230, SD, 4'b1101);

        // mid-frame reset: outputs blank immediately
        #1;
        reset = 1'b0;
        #1;
        check_eq("midrst_seg", d_seg, BLK);
        check_eq("midrst_sel", d_select, 4'hF);
        check_eq("midrst_cur", d_cur, 0);
        c_sel = 2'd3;
        release_reset();

        // ---- phase B: restart, leading zeros, out-of-range select ----
        disp("restart_pre_tick", 4, BLK, 4'b1111);
        check_eq("lz_pre_tick_sel", l_select, 4'b1111);
        disp("restart_d1_zero", 5, S0, 4'b1101);
        check_eq("lz_snap0_d1_seg", l_seg, BLK);
        check_eq("lz_snap0_d1_sel", l_select, 4'b1101);
        at(13);
        check_eq("lz_snap0_d3_seg", l_seg, BLK);
        at(16);
        check_eq("c3_sel3_cur", c_cur, 0);
        check_eq("lz_cur", l_cur, 0);
        at(17);
        check_eq("c3_d0_seg", c_seg, SD);
        check_eq("lz5_d0_seg", l_seg, S5);
        check_eq("lz5_d0_sel", l_select, 4'b1110);
        at(21);
        check_eq("lz5_d1_seg", l_seg, BLK);
        at(29);
        check_eq("lz5_d3_seg", l_seg, BLK);
        check_eq("lz5_d3_sel", l_select, 4'b0111);
        l_ch0 = 16'h0000;
        at(33);
        check_eq("lz0_d0_seg", l_seg, S0);
        at(37);
        check_eq("lz0_d1_seg", l_seg, BLK);
        l_ch0 = 16'h0105;
        at(53);
        check_eq("lz105_d1_seg", l_seg, S0);
        at(57);
        check_eq("lz105_d2_seg", l_seg, S1);
        at(61);
        check_eq("lz105_d3_seg", l_seg, BLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
